// File: rtl/tt_dfd_generic_fifo_mn_flow.sv
// Multi-push / multi-pop FIFO with ENTRIES slots (need not be a power of two).
// Latency: a pushed entry shows on o_data the cycle after the push; no fall-through.
// Backpressure: per-lane o_psh_rdy from start-of-cycle free space; dropped pushes set o_overflow.
//
// Optional build macro: TT_DFD_FIFO_MN_FLOW_WATERMARK_EN adds o_hwm (peak occupancy).
// Ports:
//   i_clk, i_reset_n (async, active-low)
//   i_data/i_psh/o_psh_rdy    : NUM_WR push lanes, set bits compacted into consecutive slots
//   i_pop/o_valid/o_data      : NUM_RD head-of-queue lanes, lane 0 = oldest, i_pop thermometer
//   i_clear                   : synchronous flush (tied off when ALLOW_CLEAR=0)
//   o_cnt/o_free/o_empty/o_almost_full : occupancy status
//   o_overflow/o_proto_err    : sticky error flags
module tt_dfd_generic_fifo_mn_flow #(
  parameter int DATA_WIDTH   = 8,
  parameter int ENTRIES      = 6,
  parameter int NUM_WR       = 3,
  parameter int NUM_RD       = 2,
  parameter int AFULL_THRESH = ENTRIES - 1,
  parameter int ALLOW_CLEAR  = 1,
  parameter int ADDR_SIZE    = $clog2(ENTRIES)
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [NUM_WR*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_WR-1:0]            i_psh,
  output logic [NUM_WR-1:0]            o_psh_rdy,
  input  logic [NUM_RD-1:0]            i_pop,
  output logic [NUM_RD-1:0]            o_valid,
  output logic [NUM_RD*DATA_WIDTH-1:0] o_data,
  input  logic                         i_clear,
  output logic [ADDR_SIZE:0]           o_cnt,
  output logic [ADDR_SIZE:0]           o_free,
  output logic                         o_empty,
  output logic                         o_almost_full,
  output logic                         o_overflow,
  output logic                         o_proto_err
`ifdef TT_DFD_FIFO_MN_FLOW_WATERMARK_EN
  ,output logic [ADDR_SIZE:0]          o_hwm
`endif
);

  localparam int CW = ADDR_SIZE + 1;
  localparam logic [CW-1:0] ENTRIES_C = CW'(ENTRIES);
  localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
  logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d, perr_q, perr_d;

  logic                  clr;
  logic [CW-1:0]         free;
  logic [NUM_WR-1:0]     psh_rdy;
  logic [NUM_WR-1:0]     psh_acc;
  logic [ADDR_SIZE-1:0]  wr_idx [NUM_WR];
  logic [CW-1:0]         acc_cnt;
  logic [NUM_RD-1:0]     valid;
  logic [NUM_RD-1:0]     pop_ok;
  logic [CW-1:0]         pop_cnt;
  logic                  pop_err;

  // Pointer advance with a single conditional subtract: both operands are
  // below ENTRIES, so the sum never needs more than one correction.
  function automatic logic [ADDR_SIZE-1:0] ptr_add(input logic [ADDR_SIZE-1:0] p,
                                                   input logic [CW-1:0] n);
    logic [CW-1:0] s;
    s = {1'b0, p} + n;
    if (s >= ENTRIES_C) s = s - ENTRIES_C;
    return s[ADDR_SIZE-1:0];
  endfunction

  assign clr  = (ALLOW_CLEAR != 0) && i_clear;
  assign free = ENTRIES_C - cnt_q;

  // Push side: running popcount gives each set lane its compacted slot and
  // its readiness. The prefix count is monotonic, so accepted lanes always
  // form a prefix of the set bits and acc_cnt is the last accepted rank.
  always_comb begin
    logic [CW-1:0] run;
    run     = '0;
    acc_cnt = '0;
    psh_rdy = '0;
    psh_acc = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      wr_idx[i]  = ptr_add(wr_ptr_q, run);
      run        = run + CW'(i_psh[i]);
      psh_rdy[i] = (run <= free);
      psh_acc[i] = i_psh[i] && psh_rdy[i];
      if (psh_acc[i]) acc_cnt = run;
    end
  end

  // Pop side: only the unbroken run of requests from lane 0 over valid
  // lanes is honoured; anything else is a protocol error.
  always_comb begin
    logic live;
    live    = 1'b1;
    pop_ok  = '0;
    pop_cnt = '0;
    valid   = '0;
    o_data  = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      valid[j]  = (cnt_q > CW'(j));
      live      = live && i_pop[j] && valid[j];
      pop_ok[j] = live;
      pop_cnt   = pop_cnt + CW'(live);
      if (valid[j]) o_data[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[ptr_add(rd_ptr_q, CW'(j))];
    end
    pop_err = |(i_pop & ~pop_ok);
  end

  always_comb begin
    cnt_d    = cnt_q + acc_cnt - pop_cnt;
    wr_ptr_d = ptr_add(wr_ptr_q, acc_cnt);
    rd_ptr_d = ptr_add(rd_ptr_q, pop_cnt);
    ovf_d    = ovf_q | (|(i_psh & ~psh_rdy));
    perr_d   = perr_q | pop_err;
    if (clr) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      perr_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
    end
  end

  // Storage is deliberately not reset; o_data is gated by o_valid instead.
  always_ff @(posedge i_clk) begin
    if (!clr) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (psh_acc[i]) mem_q[wr_idx[i]] <= i_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign o_psh_rdy     = psh_rdy;
  assign o_valid       = valid;
  assign o_cnt         = cnt_q;
  assign o_free        = free;
  assign o_empty       = (cnt_q == '0);
  assign o_almost_full = (cnt_q >= AFULL_C);
  assign o_overflow    = ovf_q;
  assign o_proto_err   = perr_q;

`ifdef TT_DFD_FIFO_MN_FLOW_WATERMARK_EN
  // Tracks registered count, so the peak appears one cycle after it is reached.
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = (cnt_q > hwm_q) ? cnt_q : hwm_q;
    if (clr) hwm_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) hwm_q <= '0;
    else            hwm_q <= hwm_d;
  end

  assign o_hwm = hwm_q;
`endif

endmodule

// File: tb/tb_tt_dfd_generic_fifo_mn_flow.sv
// Directed bench for the multi-push / multi-pop FIFO (ENTRIES=6, NUM_WR=3, NUM_RD=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Each scenario task performs its own comparisons against hand-computed values.
module tb_tt_dfd_generic_fifo_mn_flow;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [23:0] i_data = '0;
  logic [2:0]  i_psh = '0;
  logic [2:0]  o_psh_rdy;
  logic [1:0]  i_pop = '0;
  logic [1:0]  o_valid;
  logic [15:0] o_data;
  logic        i_clear = 1'b0;
  logic [3:0]  o_cnt;
  logic [3:0]  o_free;
  logic        o_empty;
  logic        o_almost_full;
  logic        o_overflow;
  logic        o_proto_err;
`ifdef TT_DFD_FIFO_MN_FLOW_WATERMARK_EN
  logic [3:0]  o_hwm;
`endif

  int checks = 0;
  int errors = 0;

  tt_dfd_generic_fifo_mn_flow dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_data(i_data), .i_psh(i_psh),
    .o_psh_rdy(o_psh_rdy), .i_pop(i_pop), .o_valid(o_valid), .o_data(o_data),
    .i_clear(i_clear), .o_cnt(o_cnt), .o_free(o_free), .o_empty(o_empty),
    .o_almost_full(o_almost_full), .o_overflow(o_overflow), .o_proto_err(o_proto_err)
`ifdef TT_DFD_FIFO_MN_FLOW_WATERMARK_EN
    , .o_hwm(o_hwm)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
    i_psh   = '0;
    i_pop   = '0;
    i_clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    #1;
    checks++; if (o_cnt !== 4'd0)       begin errors++; $display("FAIL reset_cnt got %0d want 0", o_cnt); end
    checks++; if (o_empty !== 1'b1)     begin errors++; $display("FAIL reset_empty got %b want 1", o_empty); end
    checks++; if (o_free !== 4'd6)      begin errors++; $display("FAIL reset_free got %0d want 6", o_free); end
    checks++; if (o_valid !== 2'b00)    begin errors++; $display("FAIL reset_valid got %b want 00", o_valid); end
    checks++; if (o_data !== 16'h0)     begin errors++; $display("FAIL reset_data got %h want 0000", o_data); end
    checks++; if ({o_overflow, o_proto_err, o_almost_full} !== 3'b000)
                                        begin errors++; $display("FAIL reset_flags got %b want 000", {o_overflow, o_proto_err, o_almost_full}); end
    checks++; if (o_psh_rdy !== 3'b111) begin errors++; $display("FAIL reset_rdy got %b want 111", o_psh_rdy); end
`ifdef TT_DFD_FIFO_MN_FLOW_WATERMARK_EN
    checks++; if (o_hwm !== 4'd0)       begin errors++; $display("FAIL reset_hwm got %0d want 0", o_hwm); end
`endif
  endtask

  task automatic test_compaction();
    i_psh  = 3'b101;
    i_data = {8'hB2, 8'hEE, 8'hA1};
    #1;
    checks++; if (o_valid !== 2'b00) begin errors++; $display("FAIL no_fallthrough got %b want 00", o_valid); end
    tick();
    checks++; if (o_cnt !== 4'd2)      begin errors++; $display("FAIL compact_cnt got %0d want 2", o_cnt); end
    checks++; if (o_valid !== 2'b11)   begin errors++; $display("FAIL compact_valid got %b want 11", o_valid); end
    checks++; if (o_data !== 16'hB2A1) begin errors++; $display("FAIL compact_data got %h want b2a1", o_data); end
    i_pop = 2'b11;
    tick();
    checks++; if (o_empty !== 1'b1)    begin errors++; $display("FAIL compact_drain got %b want 1", o_empty); end
  endtask

  task automatic test_fill_overflow();
    i_psh = 3'b111; i_data = {8'h03, 8'h02, 8'h01};
    tick();
    i_psh = 3'b011; i_data = {8'hFF, 8'h05, 8'h04};
    tick();
    checks++; if (o_cnt !== 4'd5)          begin errors++; $display("FAIL fill_cnt5 got %0d want 5", o_cnt); end
    checks++; if (o_almost_full !== 1'b1)  begin errors++; $display("FAIL afull_at5 got %b want 1", o_almost_full); end
    i_psh = 3'b111; i_data = {8'h08, 8'h07, 8'h06};
    #1;
    checks++; if (o_psh_rdy !== 3'b001)    begin errors++; $display("FAIL rdy_at5 got %b want 001", o_psh_rdy); end
    tick();
    checks++; if (o_cnt !== 4'd6)          begin errors++; $display("FAIL fill_cnt6 got %0d want 6", o_cnt); end
    checks++; if (o_free !== 4'd0)         begin errors++; $display("FAIL fill_free got %0d want 0", o_free); end
    checks++; if (o_overflow !== 1'b1)     begin errors++; $display("FAIL overflow got %b want 1", o_overflow); end
    checks++; if (o_data !== 16'h0201)     begin errors++; $display("FAIL fill_head got %h want 0201", o_data); end
  endtask

  task automatic test_full_push_pop();
    i_psh = 3'b111; i_data = {8'h99, 8'h99, 8'h99};
    i_pop = 2'b11;
    #1;
    checks++; if (o_psh_rdy !== 3'b000) begin errors++; $display("FAIL full_rdy got %b want 000", o_psh_rdy); end
    tick();
    checks++; if (o_cnt !== 4'd4)       begin errors++; $display("FAIL full_pp_cnt got %0d want 4", o_cnt); end
    checks++; if (o_data !== 16'h0403)  begin errors++; $display("FAIL full_pp_head got %h want 0403", o_data); end
`ifdef TT_DFD_FIFO_MN_FLOW_WATERMARK_EN
    checks++; if (o_hwm !== 4'd6)       begin errors++; $display("FAIL hwm_fill got %0d want 6", o_hwm); end
`endif
    i_clear = 1'b1;
    tick();
    checks++; if (o_cnt !== 4'd0)       begin errors++; $display("FAIL clear1_cnt got %0d want 0", o_cnt); end
    checks++; if (o_overflow !== 1'b0)  begin errors++; $display("FAIL clear1_ovf got %b want 0", o_overflow); end
  endtask

  task automatic test_wrap();
    logic [2:0] psh_tab [20];
    logic [1:0] pop_tab [20];
    logic [7:0] exp_q [$];
    psh_tab = '{3'b111, 3'b010, 3'b101, 3'b000, 3'b111, 3'b110, 3'b001, 3'b011, 3'b100, 3'b111,
                3'b000, 3'b101, 3'b111, 3'b010, 3'b001, 3'b110, 3'b000, 3'b011, 3'b100, 3'b000};
    pop_tab = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00, 2'b11,
                2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
    for (int k = 0; k < 20; k++) begin
      int free_n, rank, npop;
      logic [7:0] lane_dat [3];
      for (int l = 0; l < 3; l++) lane_dat[l] = 8'(8'h40 + k * 4 + l);
      i_psh  = psh_tab[k];
      i_pop  = pop_tab[k];
      i_data = {lane_dat[2], lane_dat[1], lane_dat[0]};
      free_n = 6 - exp_q.size();
      npop   = (pop_tab[k] == 2'b11) ? 2 : (pop_tab[k] == 2'b01) ? 1 : 0;
      if (npop > exp_q.size()) npop = exp_q.size();
      for (int p = 0; p < npop; p++) void'(exp_q.pop_front());
      rank = 0;
      for (int l = 0; l < 3; l++) begin
        if (psh_tab[k][l]) begin
          rank++;
          if (rank <= free_n) exp_q.push_back(lane_dat[l]);
        end
      end
      tick();
      checks++;
      if (o_cnt !== 4'(exp_q.size())) begin
        errors++; $display("FAIL wrap_cnt step %0d got %0d want %0d", k, o_cnt, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (o_data[7:0] !== exp_q[0]) begin
          errors++; $display("FAIL wrap_head0 step %0d got %h want %h", k, o_data[7:0], exp_q[0]);
        end
      end
      if (exp_q.size() > 1) begin
        checks++;
        if (o_data[15:8] !== exp_q[1]) begin
          errors++; $display("FAIL wrap_head1 step %0d got %h want %h", k, o_data[15:8], exp_q[1]);
        end
      end
    end
    for (int n = 0; n < 4 && exp_q.size() > 0; n++) begin
      i_pop = 2'b11;
      for (int p = 0; p < 2 && exp_q.size() > 0; p++) void'(exp_q.pop_front());
      tick();
    end
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL wrap_drain got %b want 1", o_empty); end
  endtask

  task automatic test_proto_err();
    i_psh = 3'b001; i_data = {8'h00, 8'h00, 8'h77};
    tick();
    i_pop = 2'b11;
    tick();
    checks++; if (o_cnt !== 4'd0)        begin errors++; $display("FAIL perr1_cnt got %0d want 0", o_cnt); end
    checks++; if (o_proto_err !== 1'b1)  begin errors++; $display("FAIL perr1_flag got %b want 1", o_proto_err); end
    i_clear = 1'b1;
    tick();
    checks++; if (o_proto_err !== 1'b0)  begin errors++; $display("FAIL perr_clear got %b want 0", o_proto_err); end
    i_psh = 3'b111; i_data = {8'hC3, 8'hC2, 8'hC1};
    tick();
    i_psh = 3'b001; i_data = {8'h00, 8'h00, 8'hC4};
    tick();
    i_pop = 2'b10;
    tick();
    checks++; if (o_cnt !== 4'd4)        begin errors++; $display("FAIL perr2_cnt got %0d want 4", o_cnt); end
    checks++; if (o_data !== 16'hC2C1)   begin errors++; $display("FAIL perr2_head got %h want c2c1", o_data); end
    checks++; if (o_proto_err !== 1'b1)  begin errors++; $display("FAIL perr2_flag got %b want 1", o_proto_err); end
  endtask

  task automatic test_clear();
    i_clear = 1'b1;
    i_psh   = 3'b111; i_data = {8'hD3, 8'hD2, 8'hD1};
    i_pop   = 2'b01;
    tick();
    checks++; if (o_cnt !== 4'd0)       begin errors++; $display("FAIL clear_cnt got %0d want 0", o_cnt); end
    checks++; if (o_empty !== 1'b1)     begin errors++; $display("FAIL clear_empty got %b want 1", o_empty); end
    checks++; if (o_free !== 4'd6)      begin errors++; $display("FAIL clear_free got %0d want 6", o_free); end
    checks++; if ({o_overflow, o_proto_err} !== 2'b00)
                                        begin errors++; $display("FAIL clear_flags got %b want 00", {o_overflow, o_proto_err}); end
    checks++; if (o_valid !== 2'b00)    begin errors++; $display("FAIL clear_valid got %b want 00", o_valid); end
    tick();
`ifdef TT_DFD_FIFO_MN_FLOW_WATERMARK_EN
    checks++; if (o_hwm !== 4'd0)       begin errors++; $display("FAIL clear_hwm got %0d want 0", o_hwm); end
`endif
  endtask

  task automatic test_async_reset();
    i_psh = 3'b111; i_data = {8'hE3, 8'hE2, 8'hE1};
    tick();
    checks++; if (o_cnt !== 4'd3)       begin errors++; $display("FAIL arst_pre_cnt got %0d want 3", o_cnt); end
    #2;
    i_reset_n = 1'b0;
    #1;
    checks++; if (o_cnt !== 4'd0)       begin errors++; $display("FAIL arst_cnt got %0d want 0", o_cnt); end
    checks++; if (o_empty !== 1'b1)     begin errors++; $display("FAIL arst_empty got %b want 1", o_empty); end
    checks++; if (o_free !== 4'd6)      begin errors++; $display("FAIL arst_free got %0d want 6", o_free); end
    checks++; if (o_valid !== 2'b00)    begin errors++; $display("FAIL arst_valid got %b want 00", o_valid); end
    checks++; if (o_data !== 16'h0)     begin errors++; $display("FAIL arst_data got %h want 0000", o_data); end
`ifdef TT_DFD_FIFO_MN_FLOW_WATERMARK_EN
    checks++; if (o_hwm !== 4'd0)       begin errors++; $display("FAIL arst_hwm got %0d want 0", o_hwm); end
`endif
    #2;
    i_reset_n = 1'b1;
    tick();
    checks++; if (o_cnt !== 4'd0)       begin errors++; $display("FAIL arst_post_cnt got %0d want 0", o_cnt); end
  endtask

  initial begin
    test_reset();
    test_compaction();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap();
    test_proto_err();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
